// File: rtl/piso.sv
// rtl/piso.sv - four-bit parallel-in / serial-out shift register with valid-bit counter
module piso (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       I0,
    input  logic       I1,
    input  logic       I2,
    input  logic       I3,
    input  logic       si,
    output logic       Q0,
    output logic       Q1,
    output logic       Q2,
    output logic       Q3,
    output logic [2:0] bits_left,
    output logic       sout_valid
);

    // Stage flops: load captures the nibble, otherwise shift toward Q3 filling Q0 from si
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Q0 <= 1'b0;
            Q1 <= 1'b0;
            Q2 <= 1'b0;
            Q3 <= 1'b0;
        end else if (load) begin
            Q0 <= I0;
            Q1 <= I1;
            Q2 <= I2;
            Q3 <= I3;
        end else begin
            Q3 <= Q2;
            Q2 <= Q1;
            Q1 <= Q0;
            Q0 <= si;
        end
    end

    // Remaining valid bits: reload to 4, count down on shifts, hold at 0 once drained
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bits_left <= 3'd0;
        end else if (load) begin
            bits_left <= 3'd4;
        end else if (bits_left != 3'd0) begin
            bits_left <= bits_left - 3'd1;
        end
    end

    // Q3 is meaningful only while loaded bits remain
    assign sout_valid = (bits_left != 3'd0);

endmodule

// File: tb/tb_piso.sv
// tb/tb_piso.sv - randomized and directed self-checking bench for piso
module tb_piso;

    logic       clk;
    logic       rst;
    logic       load;
    logic       I0, I1, I2, I3;
    logic       si;
    logic       Q0, Q1, Q2, Q3;
    logic [2:0] bits_left;
    logic       sout_valid;

    int checks;
    int errors;

    // Reference model: the register viewed as a 4-bit number with Q3 as its MSB
    int m_word;
    int m_left;

    piso dut (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .I0         (I0),
        .I1         (I1),
        .I2         (I2),
        .I3         (I3),
        .si         (si),
        .Q0         (Q0),
        .Q1         (Q1),
        .Q2         (Q2),
        .Q3         (Q3),
        .bits_left  (bits_left),
        .sout_valid (sout_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock edge with the given inputs; the model advances by the behavioural rules
    task automatic step(input logic ld, input logic [3:0] nib, input logic s);
        load = ld;
        {I3, I2, I1, I0} = nib;
        si = s;
        @(posedge clk);
        if (ld) begin
            m_word = int'(nib);
            m_left = 4;
        end else begin
            m_word = (m_word * 2 + int'(s)) % 16;
            m_left = (m_left > 0) ? m_left - 1 : 0;
        end
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        load = 1'b0;
        {I3, I2, I1, I0} = 4'h0;
        si = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        m_word = 0;
        m_left = 0;
    endtask

    task automatic test_reset();
        logic [3:0] exp_q;
        apply_reset();
        checks++;
        if ({Q3, Q2, Q1, Q0} !== 4'h0 || bits_left !== 3'd0 || sout_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_init: Q3..Q0=%b bits_left=%0d valid=%b, required 0000 0 0",
                     {Q3, Q2, Q1, Q0}, bits_left, sout_valid);
        end
        step(1'b1, 4'b0101, 1'b0);
        step(1'b0, 4'b0000, 1'b1);
        exp_q = m_word[3:0];
        checks++;
        if ({Q3, Q2, Q1, Q0} !== exp_q || exp_q !== 4'b1011) begin
            errors++;
            $display("FAIL reset_setup: Q3..Q0=%b, required %b", {Q3, Q2, Q1, Q0}, exp_q);
        end
        #2;
        rst = 1'b1;
        load = 1'b1;
        {I3, I2, I1, I0} = 4'hF;
        #1;
        checks++;
        if ({Q3, Q2, Q1, Q0} !== 4'h0 || bits_left !== 3'd0 || sout_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: Q3..Q0=%b bits_left=%0d valid=%b, required 0000 0 0",
                     {Q3, Q2, Q1, Q0}, bits_left, sout_valid);
        end
        @(posedge clk);
        #1;
        checks++;
        if ({Q3, Q2, Q1, Q0} !== 4'h0 || bits_left !== 3'd0) begin
            errors++;
            $display("FAIL reset_over_load: Q3..Q0=%b bits_left=%0d, required 0000 0",
                     {Q3, Q2, Q1, Q0}, bits_left);
        end
        @(negedge clk);
        rst = 1'b0;
        load = 1'b0;
        m_word = 0;
        m_left = 0;
    endtask

    task automatic test_load_shift();
        step(1'b1, 4'b0011, 1'b0);
        checks++;
        if ({Q0, Q1, Q2, Q3} !== 4'b1100 || bits_left !== 3'd4 || sout_valid !== 1'b1) begin
            errors++;
            $display("FAIL load: Q0..Q3=%b bits_left=%0d valid=%b, required 1100 4 1",
                     {Q0, Q1, Q2, Q3}, bits_left, sout_valid);
        end
        step(1'b0, 4'b0000, 1'b0);
        checks++;
        if ({Q0, Q1, Q2, Q3} !== 4'b0110 || bits_left !== 3'd3) begin
            errors++;
            $display("FAIL shift_one: Q0..Q3=%b bits_left=%0d, required 0110 3",
                     {Q0, Q1, Q2, Q3}, bits_left);
        end
    endtask

    task automatic test_serialize();
        logic [3:0] word;
        word = 4'b1011;
        step(1'b1, word, 1'b0);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (Q3 !== word[3 - k] || sout_valid !== 1'b1 || bits_left !== 3'(4 - k)) begin
                errors++;
                $display("FAIL serial_bit%0d: Q3=%b valid=%b bits_left=%0d, required %b 1 %0d",
                         k, Q3, sout_valid, bits_left, word[3 - k], 4 - k);
            end
            step(1'b0, 4'b0000, 1'b0);
        end
        checks++;
        if (Q3 !== 1'b0 || bits_left !== 3'd0 || sout_valid !== 1'b0) begin
            errors++;
            $display("FAIL serial_drain: Q3=%b bits_left=%0d valid=%b, required 0 0 0",
                     Q3, bits_left, sout_valid);
        end
    endtask

    task automatic test_back_to_back();
        step(1'b1, 4'b0111, 1'b0);
        step(1'b0, 4'b0000, 1'b0);
        checks++;
        if ({Q0, Q1, Q2, Q3} !== 4'b0111 || bits_left !== 3'd3) begin
            errors++;
            $display("FAIL b2b_shift: Q0..Q3=%b bits_left=%0d, required 0111 3",
                     {Q0, Q1, Q2, Q3}, bits_left);
        end
        step(1'b1, 4'b1100, 1'b0);
        checks++;
        if ({Q0, Q1, Q2, Q3} !== 4'b0011 || bits_left !== 3'd4) begin
            errors++;
            $display("FAIL b2b_reload: Q0..Q3=%b bits_left=%0d, required 0011 4",
                     {Q0, Q1, Q2, Q3}, bits_left);
        end
    endtask

    task automatic test_fill_saturate();
        int ones;
        step(1'b1, 4'b0000, 1'b1);
        for (int k = 1; k <= 6; k++) begin
            step(1'b0, 4'b0000, 1'b1);
            ones = (k < 4) ? k : 4;
            checks++;
            if ({Q3, Q2, Q1, Q0} !== 4'((1 << ones) - 1) || bits_left !== 3'((k < 4) ? 4 - k : 0)
                || sout_valid !== (k < 4)) begin
                errors++;
                $display("FAIL fill_shift%0d: Q3..Q0=%b bits_left=%0d valid=%b, required %b %0d %b",
                         k, {Q3, Q2, Q1, Q0}, bits_left, sout_valid, 4'((1 << ones) - 1),
                         (k < 4) ? 4 - k : 0, k < 4);
            end
        end
    endtask

    task automatic test_load_held();
        logic [3:0] nib;
        for (int k = 0; k < 3; k++) begin
            nib = 4'($urandom_range(0, 15));
            step(1'b1, nib, 1'($urandom_range(0, 1)));
            checks++;
            if ({Q3, Q2, Q1, Q0} !== nib || bits_left !== 3'd4 || sout_valid !== 1'b1) begin
                errors++;
                $display("FAIL load_held%0d: Q3..Q0=%b bits_left=%0d, required %b 4",
                         k, {Q3, Q2, Q1, Q0}, bits_left, nib);
            end
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 300; k++) begin
            step(($urandom_range(0, 3) == 0), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
            checks++;
            if ({Q3, Q2, Q1, Q0} !== m_word[3:0] || bits_left !== m_left[2:0]
                || sout_valid !== (m_left != 0)) begin
                errors++;
                $display("FAIL random%0d: Q3..Q0=%b bits_left=%0d valid=%b, required %b %0d %b",
                         k, {Q3, Q2, Q1, Q0}, bits_left, sout_valid, m_word[3:0], m_left,
                         m_left != 0);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        m_word = 0;
        m_left = 0;
        test_reset();
        test_load_shift();
        test_serialize();
        test_back_to_back();
        test_fill_saturate();
        test_load_held();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
